// File: rtl/sprite_move_sched.sv
// sprite_move_sched: turns the four raw direction buttons into one-clock step
// commands for the sprite mover.
//
// Each button is synchronised (SYNC_STAGES flops) and debounced (DB_CYCLES
// stable clocks). Opposite buttons on one axis cancel. A three-state scheduler
// (idle / issue / wait) spaces steps SLOW_DIV clocks apart, or FAST_DIV once
// ACCEL_STEPS steps have been issued with an unchanged button set. When both
// axes request, the axes take turns.
//
// Ports:
//   clk          system clock (VGA pixel clock domain)
//   reset        asynchronous, active-high reset
//   btn_*_n      raw active-low buttons, asynchronous to clk
//   axis_v       to mover enable: 1 = vertical step, 0 = horizontal
//   cmd_ur_n     to mover up_right_n, active-low one-clock pulse
//   cmd_dl_n     to mover down_left_n, active-low one-clock pulse
//   step_dir     direction of last issued step: 00 up, 01 down, 10 left, 11 right
//   fast         high while fast stepping is active
module sprite_move_sched #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 250000,
    parameter int unsigned SLOW_DIV    = 416667,
    parameter int unsigned FAST_DIV    = 104167,
    parameter int unsigned ACCEL_STEPS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    output logic       axis_v,
    output logic       cmd_ur_n,
    output logic       cmd_dl_n,
    output logic [1:0] step_dir,
    output logic       fast
);

    localparam int unsigned PerW  = $clog2(SLOW_DIV);
    localparam int unsigned DbW   = $clog2(DB_CYCLES + 1);
    localparam int unsigned StepW = $clog2(ACCEL_STEPS + 1);

    localparam logic [1:0] DirUp    = 2'b00;
    localparam logic [1:0] DirDown  = 2'b01;
    localparam logic [1:0] DirLeft  = 2'b10;
    localparam logic [1:0] DirRight = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    // Button vectors are ordered {up, down, left, right}.
    logic [3:0] btn_raw;
    logic [3:0] btn_db;
    logic [3:0] pressed;
    logic [3:0] p_prev_q;

    assign btn_raw = {btn_up_n, btn_down_n, btn_left_n, btn_right_n};

    // ------------------------------------------------------------------
    // Per-button synchroniser and debouncer
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DbW-1:0]         db_cnt_q;
        logic                   db_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q   <= '1;
                db_cnt_q <= '0;
                db_q     <= 1'b1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
                if (sync_q[SYNC_STAGES-1] == db_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == DbW'(DB_CYCLES - 1)) begin
                    db_q     <= sync_q[SYNC_STAGES-1];
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DbW'(1);
                end
            end
        end

        assign btn_db[i] = db_q;
    end

    assign pressed = ~btn_db;

    logic v_req, h_req, any_req, p_chg;
    assign v_req   = pressed[3] ^ pressed[2];
    assign h_req   = pressed[1] ^ pressed[0];
    assign any_req = v_req | h_req;
    assign p_chg   = (pressed != p_prev_q);

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [PerW-1:0]  per_cnt_q, per_cnt_d;
    logic [StepW-1:0] step_cnt_q, step_cnt_d;
    logic             fast_q, fast_d;
    logic             last_axis_q, last_axis_d;
    logic             idle_entry;
    logic             pick_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait: begin
                // The wait always runs to completion so step spacing never shrinks.
                if (per_cnt_q == '0) state_d = any_req ? StIssue : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign idle_entry = (state_d == StIdle) && (state_q != StIdle);

    // Step counting and period timer. The step being issued counts before the
    // period is chosen, so the step that reaches ACCEL_STEPS already uses the
    // fast period for the following gap.
    always_comb begin
        step_cnt_d = step_cnt_q;
        if (state_q == StIssue && step_cnt_q != StepW'(ACCEL_STEPS)) begin
            step_cnt_d = step_cnt_q + StepW'(1);
        end
        if (p_chg || idle_entry) begin
            step_cnt_d = '0;
        end
        fast_d = (step_cnt_d == StepW'(ACCEL_STEPS));

        per_cnt_d = per_cnt_q;
        if (state_q == StIssue) begin
            per_cnt_d = fast_d ? PerW'(FAST_DIV - 2) : PerW'(SLOW_DIV - 2);
        end else if (state_q == StWait && per_cnt_q != '0) begin
            per_cnt_d = per_cnt_q - PerW'(1);
        end
    end

    // With both axes requesting, alternate away from the last axis stepped.
    assign pick_v = (v_req & h_req) ? ~last_axis_q : v_req;

    logic       axis_v_q, axis_v_d;
    logic       cmd_ur_n_q, cmd_ur_n_d;
    logic       cmd_dl_n_q, cmd_dl_n_d;
    logic [1:0] step_dir_q, step_dir_d;

    // Outputs are decoded from the next state so the registered command is
    // visible exactly during the issue cycle.
    always_comb begin
        axis_v_d    = 1'b0;
        cmd_ur_n_d  = 1'b1;
        cmd_dl_n_d  = 1'b1;
        step_dir_d  = step_dir_q;
        last_axis_d = last_axis_q;
        if (state_d == StIssue) begin
            last_axis_d = pick_v;
            if (pick_v) begin
                axis_v_d = 1'b1;
                if (pressed[3]) begin
                    cmd_ur_n_d = 1'b0;
                    step_dir_d = DirUp;
                end else begin
                    cmd_dl_n_d = 1'b0;
                    step_dir_d = DirDown;
                end
            end else begin
                if (pressed[0]) begin
                    cmd_ur_n_d = 1'b0;
                    step_dir_d = DirRight;
                end else begin
                    cmd_dl_n_d = 1'b0;
                    step_dir_d = DirLeft;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_prev_q    <= '0;
            per_cnt_q   <= '0;
            step_cnt_q  <= '0;
            fast_q      <= 1'b0;
            last_axis_q <= 1'b0;
            axis_v_q    <= 1'b0;
            cmd_ur_n_q  <= 1'b1;
            cmd_dl_n_q  <= 1'b1;
            step_dir_q  <= DirDown;
        end else begin
            p_prev_q    <= pressed;
            per_cnt_q   <= per_cnt_d;
            step_cnt_q  <= step_cnt_d;
            fast_q      <= fast_d;
            last_axis_q <= last_axis_d;
            axis_v_q    <= axis_v_d;
            cmd_ur_n_q  <= cmd_ur_n_d;
            cmd_dl_n_q  <= cmd_dl_n_d;
            step_dir_q  <= step_dir_d;
        end
    end

    assign axis_v   = axis_v_q;
    assign cmd_ur_n = cmd_ur_n_q;
    assign cmd_dl_n = cmd_dl_n_q;
    assign step_dir = step_dir_q;
    assign fast     = fast_q;

endmodule

// File: tb/tb_sprite_move_sched.sv
// Testbench for sprite_move_sched: directed scenarios plus randomized button
// activity, all checked cycle by cycle against a time-based reference model.
module tb_sprite_move_sched;

    localparam int SYNC  = 2;
    localparam int DB    = 4;
    localparam int SLOW  = 10;
    localparam int FAST  = 4;
    localparam int ACCEL = 3;

    // Raw button patterns {up, down, left, right}, active-low.
    localparam logic [3:0] RelAll = 4'b1111;
    localparam logic [3:0] Up     = 4'b0111;
    localparam logic [3:0] Left   = 4'b1101;
    localparam logic [3:0] Right  = 4'b1110;
    localparam logic [3:0] UpRt   = 4'b0110;
    localparam logic [3:0] UpDn   = 4'b0011;
    localparam logic [3:0] UpDnLt = 4'b0001;

    localparam logic [5:0] RstOuts = 6'b011010; // {axis_v, ur_n, dl_n, dir, fast}

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up_n = 1'b1, btn_down_n = 1'b1, btn_left_n = 1'b1, btn_right_n = 1'b1;
    logic       axis_v, cmd_ur_n, cmd_dl_n, fast;
    logic [1:0] step_dir;
    logic [5:0] dut_outs;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sprite_move_sched #(
        .SYNC_STAGES(SYNC),
        .DB_CYCLES  (DB),
        .SLOW_DIV   (SLOW),
        .FAST_DIV   (FAST),
        .ACCEL_STEPS(ACCEL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up_n   (btn_up_n),
        .btn_down_n (btn_down_n),
        .btn_left_n (btn_left_n),
        .btn_right_n(btn_right_n),
        .axis_v     (axis_v),
        .cmd_ur_n   (cmd_ur_n),
        .cmd_dl_n   (cmd_dl_n),
        .step_dir   (step_dir),
        .fast       (fast)
    );

    assign dut_outs = {axis_v, cmd_ur_n, cmd_dl_n, step_dir, fast};

    // ------------------------------------------------------------------
    // Reference model: raw samples travel through a delay queue, debounce is
    // a run-length of disagreeing samples, and stepping is tracked as the
    // clock edge at which the current gap expires.
    // ------------------------------------------------------------------
    logic [3:0] m_syncq[$];
    logic [3:0] m_db;
    int         m_run[4];
    logic [3:0] m_p_prev;
    bit         m_idle, m_issued, m_fast, m_last_v;
    int         m_edge, m_next_ok, m_steps;
    logic       m_axis, m_ur, m_dl;
    logic [1:0] m_dir;

    function automatic logic [5:0] m_outs();
        return {m_axis, m_ur, m_dl, m_dir, m_fast};
    endfunction

    function automatic void model_reset();
        m_syncq.delete();
        for (int i = 0; i < SYNC; i++) m_syncq.push_back(4'hF);
        m_db = 4'hF;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_p_prev = 4'h0;
        m_idle = 1; m_issued = 0; m_fast = 0; m_last_v = 0;
        m_edge = 0; m_next_ok = 0; m_steps = 0;
        m_axis = 0; m_ur = 1; m_dl = 1; m_dir = 2'b01;
    endfunction

    function automatic void model_edge(input logic [3:0] raw);
        logic [3:0] p, synced;
        bit v, h, issue, enter_idle, clr, vert;
        m_edge++;
        p = ~m_db;
        v = p[3] ^ p[2];
        h = p[1] ^ p[0];
        clr = (p != m_p_prev);
        issue = 0;
        enter_idle = 0;
        if (m_idle) begin
            if (v || h) issue = 1;
        end else if (!m_issued && m_edge == m_next_ok) begin
            if (v || h) issue = 1;
            else begin
                m_idle = 1;
                enter_idle = 1;
            end
        end
        if (m_issued && m_steps < ACCEL) m_steps++;
        if (clr || enter_idle) m_steps = 0;
        m_fast = (m_steps == ACCEL);
        if (m_issued) m_next_ok = m_edge - 1 + (m_fast ? FAST : SLOW);
        m_issued = issue;
        m_axis = 0; m_ur = 1; m_dl = 1;
        if (issue) begin
            m_idle = 0;
            vert = (v && h) ? !m_last_v : v;
            m_last_v = vert;
            m_axis = vert;
            if (vert) begin
                if (p[3]) begin m_ur = 0; m_dir = 2'b00; end
                else begin m_dl = 0; m_dir = 2'b01; end
            end else begin
                if (p[0]) begin m_ur = 0; m_dir = 2'b11; end
                else begin m_dl = 0; m_dir = 2'b10; end
            end
        end
        m_p_prev = p;
        synced = m_syncq[0];
        for (int i = 0; i < 4; i++) begin
            if (synced[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_db[i] = synced[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        void'(m_syncq.pop_front());
        m_syncq.push_back(raw);
    endfunction

    // One clock: drive buttons, advance the model at the edge, return at negedge.
    task automatic tick(input logic [3:0] raw);
        {btn_up_n, btn_down_n, btn_left_n, btn_right_n} = raw;
        @(posedge clk);
        model_edge(raw);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        {btn_up_n, btn_down_n, btn_left_n, btn_right_n} = RelAll;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic settle();
        for (int c = 0; c < 30; c++) tick(RelAll);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (dut_outs !== RstOuts) begin
            tests_failed++;
            $display("FAIL reset_values outputs %b, required %b", dut_outs, RstOuts);
        end
        {btn_up_n, btn_down_n, btn_left_n, btn_right_n} = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (dut_outs !== RstOuts) begin
            tests_failed++;
            $display("FAIL reset_held outputs %b, required %b", dut_outs, RstOuts);
        end
        {btn_up_n, btn_down_n, btn_left_n, btn_right_n} = RelAll;
        reset = 1'b0;
        model_reset();
        for (int c = 1; c <= 10; c++) begin
            tick(RelAll);
            tests_run++;
            if (dut_outs !== m_outs()) begin
                tests_failed++;
                $display("FAIL reset_idle cycle %0d outputs %b, required %b", c, dut_outs, m_outs());
            end
        end
    endtask

    task automatic test_hold_up();
        int pulses[$];
        int exp_gap[4] = '{SLOW, SLOW, FAST, FAST};
        for (int c = 1; c <= 60; c++) begin
            tick(Up);
            tests_run++;
            if (dut_outs !== m_outs()) begin
                tests_failed++;
                $display("FAIL hold_up cycle %0d outputs %b, required %b", c, dut_outs, m_outs());
            end
            if (cmd_ur_n === 1'b0) begin
                pulses.push_back(c);
                tests_run++;
                if ({axis_v, cmd_dl_n, step_dir} !== 4'b1100) begin
                    tests_failed++;
                    $display("FAIL hold_up_cmd cycle %0d axis/dl/dir %b, required 1100",
                             c, {axis_v, cmd_dl_n, step_dir});
                end
            end
            if (pulses.size() == 3 && c == pulses[2] + 1) begin
                tests_run++;
                if (fast !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL hold_up_fast after pulse 3 fast %b, required 1", fast);
                end
            end
        end
        tests_run++;
        if (pulses.size() < 5) begin
            tests_failed++;
            $display("FAIL hold_up_count pulses %0d, required >= 5", pulses.size());
        end else begin
            tests_run++;
            if (pulses[0] != SYNC + DB + 1) begin
                tests_failed++;
                $display("FAIL hold_up_latency first pulse %0d, required %0d", pulses[0],
                         SYNC + DB + 1);
            end
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (pulses[k+1] - pulses[k] != exp_gap[k]) begin
                    tests_failed++;
                    $display("FAIL hold_up_gap %0d gap %0d, required %0d", k + 1,
                             pulses[k+1] - pulses[k], exp_gap[k]);
                end
            end
        end
        settle();
    endtask

    task automatic test_glitch();
        int npulse = 0;
        for (int c = 1; c <= 33; c++) begin
            tick(c <= 3 ? Left : RelAll);
            tests_run++;
            if (dut_outs !== m_outs()) begin
                tests_failed++;
                $display("FAIL glitch cycle %0d outputs %b, required %b", c, dut_outs, m_outs());
            end
            if (cmd_ur_n === 1'b0 || cmd_dl_n === 1'b0) npulse++;
        end
        tests_run++;
        if (npulse != 0) begin
            tests_failed++;
            $display("FAIL glitch_pulses count %0d, required 0", npulse);
        end
    endtask

    task automatic test_diag();
        int   pc[$];
        logic pax[$];
        logic [1:0] pdir[$];
        apply_reset();
        for (int c = 1; c <= 40; c++) begin
            tick(UpRt);
            tests_run++;
            if (dut_outs !== m_outs()) begin
                tests_failed++;
                $display("FAIL diag cycle %0d outputs %b, required %b", c, dut_outs, m_outs());
            end
            if (cmd_ur_n === 1'b0 || cmd_dl_n === 1'b0) begin
                pc.push_back(c);
                pax.push_back(axis_v);
                pdir.push_back(step_dir);
            end
        end
        tests_run++;
        if (pc.size() < 4) begin
            tests_failed++;
            $display("FAIL diag_count pulses %0d, required >= 4", pc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if ({pax[k], pdir[k]} !== ((k % 2 == 0) ? 3'b100 : 3'b011)) begin
                    tests_failed++;
                    $display("FAIL diag_axis pulse %0d axis/dir %b, required %b", k + 1,
                             {pax[k], pdir[k]}, (k % 2 == 0) ? 3'b100 : 3'b011);
                end
            end
            tests_run++;
            if (pc[1] - pc[0] != SLOW || pc[2] - pc[1] != SLOW) begin
                tests_failed++;
                $display("FAIL diag_gap gaps %0d %0d, required %0d", pc[1] - pc[0],
                         pc[2] - pc[1], SLOW);
            end
        end
        settle();
    endtask

    task automatic test_cancel();
        int npulse = 0;
        bit seen_fast = 0;
        bit cleared = 0;
        for (int c = 1; c <= 30; c++) begin
            tick(UpDn);
            tests_run++;
            if (dut_outs !== m_outs()) begin
                tests_failed++;
                $display("FAIL cancel_vert cycle %0d outputs %b, required %b", c, dut_outs,
                         m_outs());
            end
            if (cmd_ur_n === 1'b0 || cmd_dl_n === 1'b0) npulse++;
        end
        tests_run++;
        if (npulse != 0) begin
            tests_failed++;
            $display("FAIL cancel_none pulses %0d, required 0", npulse);
        end
        for (int c = 1; c <= 90; c++) begin
            tick(c <= 60 ? UpDnLt : Left);
            tests_run++;
            if (dut_outs !== m_outs()) begin
                tests_failed++;
                $display("FAIL cancel_left cycle %0d outputs %b, required %b", c, dut_outs,
                         m_outs());
            end
            if (cmd_ur_n === 1'b0 || cmd_dl_n === 1'b0) begin
                npulse++;
                tests_run++;
                if ({axis_v, cmd_ur_n, cmd_dl_n, step_dir} !== 5'b01010) begin
                    tests_failed++;
                    $display("FAIL cancel_cmd cycle %0d axis/ur/dl/dir %b, required 01010", c,
                             {axis_v, cmd_ur_n, cmd_dl_n, step_dir});
                end
            end
            if (c <= 60 && fast === 1'b1) seen_fast = 1;
            if (c > 60 && seen_fast && fast === 1'b0) cleared = 1;
        end
        tests_run++;
        if (!(npulse >= 3 && seen_fast && cleared)) begin
            tests_failed++;
            $display("FAIL cancel_fast pulses %0d fast_seen %0d cleared %0d, required >=3 1 1",
                     npulse, seen_fast, cleared);
        end
        settle();
    endtask

    task automatic test_release_wait();
        int first = 0;
        int npulse = 0;
        int pc[$];
        bit fast_seen = 0;
        for (int c = 1; c <= 20 && first == 0; c++) begin
            tick(Right);
            if (cmd_ur_n === 1'b0) first = c;
        end
        tests_run++;
        if (first == 0) begin
            tests_failed++;
            $display("FAIL release_first no pulse within 20 cycles, required one");
        end
        for (int c = 1; c <= 42; c++) begin
            tick(c <= 2 ? Right : RelAll);
            tests_run++;
            if (dut_outs !== m_outs()) begin
                tests_failed++;
                $display("FAIL release cycle %0d outputs %b, required %b", c, dut_outs, m_outs());
            end
            if (cmd_ur_n === 1'b0 || cmd_dl_n === 1'b0) npulse++;
        end
        tests_run++;
        if (npulse != 0) begin
            tests_failed++;
            $display("FAIL release_none pulses %0d, required 0", npulse);
        end
        for (int c = 1; c <= 25; c++) begin
            tick(Right);
            tests_run++;
            if (dut_outs !== m_outs()) begin
                tests_failed++;
                $display("FAIL repress cycle %0d outputs %b, required %b", c, dut_outs, m_outs());
            end
            if (cmd_ur_n === 1'b0) pc.push_back(c);
            if (fast !== 1'b0) fast_seen = 1;
        end
        tests_run++;
        if (pc.size() != 2 || pc[0] != SYNC + DB + 1 || pc[1] - pc[0] != SLOW || fast_seen) begin
            tests_failed++;
            $display("FAIL repress_timing pulses %0d first %0d fast %0d, required 2 %0d 0",
                     pc.size(), pc.size() > 0 ? pc[0] : -1, fast_seen, SYNC + DB + 1);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        int first = 0;
        for (int c = 1; c <= 60 && !hit; c++) begin
            tick(Up);
            if (cmd_ur_n === 1'b0 && fast === 1'b1) hit = 1;
        end
        tests_run++;
        if (!hit) begin
            tests_failed++;
            $display("FAIL reset_mid_setup no fast pulse within 60 cycles, required one");
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (dut_outs !== RstOuts) begin
            tests_failed++;
            $display("FAIL reset_mid_async outputs %b, required %b", dut_outs, RstOuts);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int c = 1; c <= 20; c++) begin
            tick(Up);
            tests_run++;
            if (dut_outs !== m_outs()) begin
                tests_failed++;
                $display("FAIL reset_mid cycle %0d outputs %b, required %b", c, dut_outs,
                         m_outs());
            end
            if (cmd_ur_n === 1'b0 && first == 0) first = c;
        end
        tests_run++;
        if (first != SYNC + DB + 1) begin
            tests_failed++;
            $display("FAIL reset_mid_restart first pulse %0d, required %0d", first, SYNC + DB + 1);
        end
        settle();
    endtask

    task automatic test_random();
        logic [3:0] raw;
        int len;
        for (int s = 0; s < 150; s++) begin
            raw = 4'($urandom_range(0, 15));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
            for (int c = 0; c < len; c++) begin
                tick(raw);
                tests_run++;
                if (dut_outs !== m_outs()) begin
                    tests_failed++;
                    $display("FAIL random seg %0d raw %b outputs %b, required %b", s, raw,
                             dut_outs, m_outs());
                end
                tests_run++;
                if (cmd_ur_n === 1'b0 && cmd_dl_n === 1'b0) begin
                    tests_failed++;
                    $display("FAIL random_exclusive seg %0d ur/dl %b%b, required not 00", s,
                             cmd_ur_n, cmd_dl_n);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hold_up();
        test_glitch();
        test_diag();
        test_cancel();
        test_release_wait();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sprite_move_sched.md
Name: sprite_move_sched

Overview:
Step scheduler that drives the sprite-movement datapath from the four board direction buttons. It synchronises and debounces the buttons and arbitrates between the vertical and horizontal axes. It issues one-clock step commands on the mover's axis-select and active-low up/right and down/left inputs, at a programmable rate with hold-to-accelerate. It sits between the raw button pins and the sprite mover, in the same clk domain as the VGA pixel clock.

Parameters:
SYNC_STAGES, 2, flip-flop stages per button synchroniser (>=2)
DB_CYCLES, 250000, consecutive stable clocks before a debounced button changes (>=1)
SLOW_DIV, 416667, clocks between steps in normal mode (>=2)
FAST_DIV, 104167, clocks between steps in fast mode (2 <= FAST_DIV <= SLOW_DIV)
ACCEL_STEPS, 32, consecutive steps with an unchanged button set before fast mode (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_up_n  in  1  raw up button, active-low, asynchronous
btn_down_n  in  1  raw down button, active-low, asynchronous
btn_left_n  in  1  raw left button, active-low, asynchronous
btn_right_n  in  1  raw right button, active-low, asynchronous
axis_v  out  1  to mover enable: 1 = vertical step, 0 = horizontal
cmd_ur_n  out  1  to mover up_right_n, active-low, one-clock pulse
cmd_dl_n  out  1  to mover down_left_n, active-low, one-clock pulse
step_dir  out  2  direction of the last issued step: 00 up, 01 down, 10 left, 11 right
fast  out  1  1 while fast mode is active

Behaviour:
- Reset is asynchronous and active-high; clock is clk. All outputs are registered.
- Reset values: axis_v=0, cmd_ur_n=1, cmd_dl_n=1, step_dir=01, fast=0. Debounced buttons reset to released, FSM to IDLE, counters to 0. last_axis resets to horizontal.
- Synchroniser: each button passes through SYNC_STAGES flops. Synchroniser flops reset to 1 (released).
- Debounce: a per-button counter increments while the synced value differs from the debounced value and clears when they match. When the count reaches DB_CYCLES-1, the debounced value takes the synced value on that clock.
- Pressed vector P = {up, down, left, right}, active-high, derived from the debounced buttons.
- V = up XOR down. H = left XOR right. Opposite buttons on one axis cancel that axis.
- FSM states:
  - IDLE: outputs inactive. If V|H, go to ISSUE next clock.
  - ISSUE: exactly one clock with the selected command asserted. The period counter is loaded with (fast ? FAST_DIV : SLOW_DIV) - 2. Go to WAIT.
  - WAIT: the counter decrements each clock. When it reaches 0: go to ISSUE if V|H, otherwise go to IDLE.
- Step spacing: consecutive ISSUE cycles are exactly SLOW_DIV or FAST_DIV clocks apart. Releasing a button during WAIT does not shorten WAIT, so the minimum step spacing is always enforced.
- Axis selection in ISSUE:
  - If both V and H: choose the axis opposite to last_axis.
  - Otherwise choose the requesting axis.
  - last_axis updates to the chosen axis.
- Command mapping in ISSUE:
  - up: axis_v=1, cmd_ur_n=0
  - down: axis_v=1, cmd_dl_n=0
  - right: axis_v=0, cmd_ur_n=0
  - left: axis_v=0, cmd_dl_n=0
- Outside ISSUE: cmd_ur_n=cmd_dl_n=1 and axis_v=0. Both command outputs are never low in the same cycle.
- step_dir updates in the ISSUE cycle and holds otherwise.
- Acceleration:
  - step_cnt counts issued steps and saturates at ACCEL_STEPS. fast=1 when step_cnt==ACCEL_STEPS.
  - step_cnt and fast clear on entry to IDLE, and on any clock where P differs from its registered previous value.
  - The clear takes priority over an increment in the same cycle.
- Counter widths: $clog2(SLOW_DIV) for the period counter, $clog2(DB_CYCLES+1) for debounce counters, $clog2(ACCEL_STEPS+1) for step_cnt. No wrap occurs under legal parameters.
- Reset mid-operation: outputs return to reset values immediately (asynchronous), including during an ISSUE pulse.

Test Plan:
(Parameters for all scenarios: SYNC_STAGES=2, DB_CYCLES=4, SLOW_DIV=10, FAST_DIV=4, ACCEL_STEPS=3.)
1. Hold btn_up_n=0 from cycle 0 -> first one-clock pulse cmd_ur_n=0, axis_v=1, step_dir=00 after sync plus debounce plus one clock. Pulses 2 and 3 each follow 10 clocks after the previous pulse. fast=1 after pulse 3, and all later pulses are 4 clocks apart.
2. Glitch btn_left_n low for 3 clocks, then high -> no pulse ever, debounced state stays released, FSM stays IDLE.
3. Hold up and right together -> pulse sequence alternates: vertical ur (step_dir 00), horizontal ur (11), vertical, ..., starting with vertical. Spacing 10 clocks.
4. Hold up and down -> no pulses. Then add left -> only cmd_dl_n pulses with axis_v=0, step_dir=10. The P change clears fast.
5. Release the button 2 clocks into WAIT -> no further pulses, FSM reaches IDLE at counter expiry. Re-press -> slow spacing (10), fast=0.
6. Assert reset during the ISSUE cycle -> cmd_ur_n=1, cmd_dl_n=1, axis_v=0, step_dir=01, fast=0 in the same cycle. After release with the button still held, stepping restarts only after the full sync plus debounce latency.
